// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: it captures the decoded instruction, inserts bubbles for stall and flush, and freezes on memory wait.
// Define ID_EX_PERF_CNT_EN to build the bubble/flush performance counters; otherwise both counter outputs are tied to zero.
module id_ex_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int          ASEL_W   = 2,
    parameter int          BSEL_W   = 2,
    parameter int          WBSEL_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     pc_di,
    input  logic [31:0]         inst_di,
    input  logic [XLEN-1:0]     rs1_data_di,
    input  logic [XLEN-1:0]     rs2_data_di,
    input  logic [XLEN-1:0]     imm_di,
    input  logic [ASEL_W-1:0]   ASel_di,
    input  logic [BSEL_W-1:0]   BSel_di,
    input  logic [BSEL_W-1:0]   REGBSel_di,
    input  logic [3:0]          ALUSel_di,
    input  logic [WBSEL_W-1:0]  WBSel_di,
    input  logic                RegWEn_di,
    input  logic                MemRW_di,
    input  logic [4:0]          AddrD_di,
    input  logic                pc_stopFlag_i,
    input  logic                flush_i,
    input  logic                mem_wait_i,
    output logic [XLEN-1:0]     pc_eo,
    output logic [31:0]         inst_eo,
    output logic [XLEN-1:0]     rs1_data_eo,
    output logic [XLEN-1:0]     rs2_data_eo,
    output logic [XLEN-1:0]     imm_eo,
    output logic [ASEL_W-1:0]   ASel_eo,
    output logic [BSEL_W-1:0]   BSel_eo,
    output logic [BSEL_W-1:0]   REGBSel_eo,
    output logic [3:0]          ALUSel_eo,
    output logic [WBSEL_W-1:0]  WBSel_eo,
    output logic                RegWEn_eo,
    output logic                MemRW_eo,
    output logic [4:0]          AddrD_eo,
    output logic                valid_eo,
    output logic [31:0]         bubble_cnt_o,
    output logic [31:0]         flush_cnt_o
);

    // Operand-select encodings. A bubble uses the plain register-file paths and ALU write-back.
    localparam logic [ASEL_W-1:0]  ASEL_REG  = '0;
    localparam logic [BSEL_W-1:0]  BSEL_REG  = '0;
    localparam logic [WBSEL_W-1:0] WBSEL_ALU = WBSEL_W'(1);

    logic kill;

    always_comb begin
        kill = flush_i | pc_stopFlag_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_eo       <= '0;
            inst_eo     <= NOP_INST;
            rs1_data_eo <= '0;
            rs2_data_eo <= '0;
            imm_eo      <= '0;
            ASel_eo     <= ASEL_REG;
            BSel_eo     <= BSEL_REG;
            REGBSel_eo  <= BSEL_REG;
            ALUSel_eo   <= '0;
            WBSel_eo    <= WBSEL_ALU;
            RegWEn_eo   <= 1'b0;
            MemRW_eo    <= 1'b0;
            AddrD_eo    <= '0;
            valid_eo    <= 1'b0;
        end else if (!mem_wait_i) begin
            pc_eo <= pc_di;
            if (kill) begin
                // A bubble must not write state or match any forwarding source, so its destination is x0.
                inst_eo     <= NOP_INST;
                rs1_data_eo <= '0;
                rs2_data_eo <= '0;
                imm_eo      <= '0;
                ASel_eo     <= ASEL_REG;
                BSel_eo     <= BSEL_REG;
                REGBSel_eo  <= BSEL_REG;
                ALUSel_eo   <= '0;
                WBSel_eo    <= WBSEL_ALU;
                RegWEn_eo   <= 1'b0;
                MemRW_eo    <= 1'b0;
                AddrD_eo    <= '0;
                valid_eo    <= 1'b0;
            end else begin
                inst_eo     <= inst_di;
                rs1_data_eo <= rs1_data_di;
                rs2_data_eo <= rs2_data_di;
                imm_eo      <= imm_di;
                ASel_eo     <= ASel_di;
                BSel_eo     <= BSel_di;
                REGBSel_eo  <= REGBSel_di;
                ALUSel_eo   <= ALUSel_di;
                WBSel_eo    <= WBSel_di;
                RegWEn_eo   <= RegWEn_di;
                MemRW_eo    <= MemRW_di;
                AddrD_eo    <= AddrD_di;
                valid_eo    <= 1'b1;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;

    // When flush and stall arrive together, the bubble is counted as a flush only.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!mem_wait_i) begin
            if (flush_i) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else if (pc_stopFlag_i) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt;
    assign flush_cnt_o  = flush_cnt;
`else
    assign bubble_cnt_o = 32'h0;
    assign flush_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg, using a behavioural model of the execute slot and counters.
module tb_id_ex_reg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [1:0]  ASEL_REG = 2'd0, ASEL_ALU = 2'd2;
    localparam logic [1:0]  BSEL_REG = 2'd0, BSEL_DATAD = 2'd3;
    localparam logic [1:0]  WBSEL_ALU = 2'd1;

    typedef struct packed {
        logic [31:0] pc, inst, rs1, rs2, imm;
        logic [1:0]  asel, bsel, rbsel;
        logic [3:0]  alu;
        logic [1:0]  wb;
        logic        regwen, memrw;
        logic [4:0]  addrd;
        logic        valid;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1, stop = 1'b0, flush = 1'b0, mwait = 1'b0;
    slot_t in;
    slot_t exp_s;
    logic [31:0] exp_bcnt, exp_fcnt;
    int n_chk = 0, n_pass = 0;

    logic [31:0] pc_eo, inst_eo, rs1_eo, rs2_eo, imm_eo, bcnt_o, fcnt_o;
    logic [1:0]  asel_eo, bsel_eo, rbsel_eo, wb_eo;
    logic [3:0]  alu_eo;
    logic        regwen_eo, memrw_eo, valid_eo;
    logic [4:0]  addrd_eo;

    id_ex_reg dut (
        .clk(clk), .rst(rst),
        .pc_di(in.pc), .inst_di(in.inst), .rs1_data_di(in.rs1), .rs2_data_di(in.rs2),
        .imm_di(in.imm), .ASel_di(in.asel), .BSel_di(in.bsel), .REGBSel_di(in.rbsel),
        .ALUSel_di(in.alu), .WBSel_di(in.wb), .RegWEn_di(in.regwen), .MemRW_di(in.memrw),
        .AddrD_di(in.addrd), .pc_stopFlag_i(stop), .flush_i(flush), .mem_wait_i(mwait),
        .pc_eo(pc_eo), .inst_eo(inst_eo), .rs1_data_eo(rs1_eo), .rs2_data_eo(rs2_eo),
        .imm_eo(imm_eo), .ASel_eo(asel_eo), .BSel_eo(bsel_eo), .REGBSel_eo(rbsel_eo),
        .ALUSel_eo(alu_eo), .WBSel_eo(wb_eo), .RegWEn_eo(regwen_eo), .MemRW_eo(memrw_eo),
        .AddrD_eo(addrd_eo), .valid_eo(valid_eo),
        .bubble_cnt_o(bcnt_o), .flush_cnt_o(fcnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    endtask

    function automatic slot_t bubble_of(input logic [31:0] pc);
        slot_t b;
        b = '0;
        b.pc = pc;
        b.inst = NOP;
        b.asel = ASEL_REG;
        b.bsel = BSEL_REG;
        b.rbsel = BSEL_REG;
        b.wb = WBSEL_ALU;
        return b;
    endfunction

    // Counter outputs read zero when the performance counters are not built.
    function automatic logic [31:0] cnt_view(input logic [31:0] c);
`ifdef ID_EX_PERF_CNT_EN
        return c;
`else
        return c & 32'h0;
`endif
    endfunction

    task automatic model_edge();
        if (rst) begin
            exp_s = bubble_of(32'h0);
            exp_bcnt = 0;
            exp_fcnt = 0;
        end else if (mwait) begin
            exp_s = exp_s;
        end else if (flush) begin
            exp_s = bubble_of(in.pc);
            exp_fcnt = exp_fcnt + 1;
        end else if (stop) begin
            exp_s = bubble_of(in.pc);
            exp_bcnt = exp_bcnt + 1;
        end else begin
            exp_s = in;
            exp_s.valid = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("pc", 64'(pc_eo), 64'(exp_s.pc));
        chk("inst", 64'(inst_eo), 64'(exp_s.inst));
        chk("rs1", 64'(rs1_eo), 64'(exp_s.rs1));
        chk("rs2", 64'(rs2_eo), 64'(exp_s.rs2));
        chk("imm", 64'(imm_eo), 64'(exp_s.imm));
        chk("asel", 64'(asel_eo), 64'(exp_s.asel));
        chk("bsel", 64'(bsel_eo), 64'(exp_s.bsel));
        chk("regbsel", 64'(rbsel_eo), 64'(exp_s.rbsel));
        chk("alusel", 64'(alu_eo), 64'(exp_s.alu));
        chk("wbsel", 64'(wb_eo), 64'(exp_s.wb));
        chk("regwen", 64'(regwen_eo), 64'(exp_s.regwen));
        chk("memrw", 64'(memrw_eo), 64'(exp_s.memrw));
        chk("addrd", 64'(addrd_eo), 64'(exp_s.addrd));
        chk("valid", 64'(valid_eo), 64'(exp_s.valid));
        chk("bubble_cnt", 64'(bcnt_o), 64'(cnt_view(exp_bcnt)));
        chk("flush_cnt", 64'(fcnt_o), 64'(cnt_view(exp_fcnt)));
    endtask

    task automatic rand_in();
        in.pc = $urandom;
        in.inst = $urandom;
        in.rs1 = $urandom;
        in.rs2 = $urandom;
        in.imm = $urandom;
        in.asel = 2'($urandom);
        in.bsel = 2'($urandom);
        in.rbsel = 2'($urandom);
        in.alu = 4'($urandom);
        in.wb = 2'($urandom);
        in.regwen = 1'($urandom);
        in.memrw = 1'($urandom);
        in.addrd = 5'($urandom);
        in.valid = 1'b0;
    endtask

    // Apply controls, advance one edge, and compare every output against the model.
    task automatic step(input logic r, input logic w, input logic f, input logic s);
        rst = r;
        mwait = w;
        flush = f;
        stop = s;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        exp_s = bubble_of(32'h0);
        exp_bcnt = 0;
        exp_fcnt = 0;
        rand_in();
        #1;

        // Reset holds a bubble even with a live instruction at the input.
        in.inst = 32'h00500093;
        in.regwen = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_inst", 64'(inst_eo), 64'h13);
        chk("rst_valid", 64'(valid_eo), 64'h0);
        chk("rst_regwen", 64'(regwen_eo), 64'h0);
        step(0, 0, 0, 0);
        chk("load_inst", 64'(inst_eo), 64'h00500093);
        chk("load_valid", 64'(valid_eo), 64'h1);

        // Load-use stall
        rand_in();
        in.regwen = 1'b1;
        in.addrd = 5'd5;
        step(0, 0, 0, 1);
        chk("stall_regwen", 64'(regwen_eo), 64'h0);
        chk("stall_addrd", 64'(addrd_eo), 64'h0);
        step(0, 0, 0, 0);
        chk("after_stall_addrd", 64'(addrd_eo), 64'h5);

        // Flush and stall together count as a flush
        step(0, 0, 1, 1);
        rand_in();
        step(0, 0, 0, 0);

        // Freeze with flush pending and a changing instruction
        for (int i = 0; i < 3; i++) begin
            rand_in();
            step(0, 1, 1, 0);
        end
        step(0, 1, 0, 1);

        // Forwarding selects pass through, bubbles force register paths
        rand_in();
        in.asel = ASEL_ALU;
        in.bsel = BSEL_DATAD;
        step(0, 0, 0, 0);
        chk("fwd_asel", 64'(asel_eo), 64'(ASEL_ALU));
        chk("fwd_bsel", 64'(bsel_eo), 64'(BSEL_DATAD));
        step(0, 0, 0, 1);
        chk("bub_asel", 64'(asel_eo), 64'(ASEL_REG));

        // Ten back-to-back stalls
        for (int i = 0; i < 10; i++) begin
            rand_in();
            step(0, 0, 0, 1);
        end

`ifdef ID_EX_PERF_CNT_EN
        force dut.bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt;
        exp_bcnt = 32'hFFFF_FFFF;
        step(0, 0, 0, 1);
        chk("wrap", 64'(bcnt_o), 64'h0);
`endif

        // Reset asserted mid-freeze wins
        step(0, 1, 0, 0);
        step(1, 1, 1, 1);
        step(0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            rand_in();
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 25));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register of the five-stage core. It sits directly downstream of the decode-stage forwarding unit. Each cycle it captures the decoded instruction, operands, control word and forwarded operand selects into the execute stage. It also converts the load-use stall flag and the execute-stage branch flush into bubbles, and freezes whole when memory is busy.

## Interface
- `XLEN`, 32, data/address width.
- `NOP_INST`, 32'h00000013, instruction word placed in a bubble (`addi x0,x0,0`).
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_di` in XLEN: decode PC.
- `inst_di` in 32: decode instruction.
- `rs1_data_di`, `rs2_data_di`, `imm_di` in XLEN: register-file reads and immediate.
- `ASel_di` in `ASEL_BUS`: forwarded A select.
- `BSel_di`, `REGBSel_di` in `BSEL_BUS`: forwarded B and store-data selects.
- `ALUSel_di` in 4: ALU operation.
- `WBSel_di` in `WBSEL_BUS`: write-back source.
- `RegWEn_di` in 1: register write enable.
- `MemRW_di` in 1: store enable.
- `AddrD_di` in 5: destination register.
- `pc_stopFlag_i` in 1: load-use stall from forwarding.
- `flush_i` in 1: branch/jump taken in execute.
- `mem_wait_i` in 1: data memory not ready; freeze.
- Outputs `pc_eo`, `inst_eo`, `rs1_data_eo`, `rs2_data_eo`, `imm_eo`, `ASel_eo`, `BSel_eo`, `REGBSel_eo`, `ALUSel_eo`, `WBSel_eo`, `RegWEn_eo`, `MemRW_eo`, `AddrD_eo`: registered copies, same widths.
- `valid_eo` out 1: execute slot holds a real instruction.
- `bubble_cnt_o`, `flush_cnt_o` out 32: performance counters (see Configuration).

## Operation
- One action per cycle, in priority order: RESET > FREEZE > FLUSH > BUBBLE > LOAD.
- RESET (`rst`=1): bubble contents, `valid_eo`=0, counters=0.
- FREEZE (`mem_wait_i`=1): every register holds, counters included. Stall and flush are ignored this cycle. The flush source is in the frozen stage, so it re-asserts after unfreeze.
- FLUSH (`flush_i`=1): load bubble. `flush_cnt` +1.
- BUBBLE (`pc_stopFlag_i`=1, no flush): load bubble. `bubble_cnt` +1. The upstream PC/IF-ID stage holds, so the same instruction is re-presented next cycle with updated forwarding selects.
- LOAD: capture all `*_di` into `*_eo`, `valid_eo`=1.
- Bubble contents:
  - `inst_eo`=`NOP_INST`, `pc_eo`=`pc_di`.
  - data/imm=0, `AddrD_eo`=0.
  - `RegWEn_eo`=0, `MemRW_eo`=0.
  - `WBSel_eo`=`WBSEL_ALU`, `ASel_eo`=`ASEL_REG`, `BSel_eo`=`REGBSel_eo`=`BSEL_REG`, `ALUSel_eo`=0.
  - `valid_eo`=0.
- A bubble must never write the register file or memory, and never trigger forwarding: `RegWEn`=0, `AddrD`=x0.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- Latency: 1 cycle, `*_di` at edge N appears on `*_eo` after edge N.
- All outputs are registered; there is no combinational input-to-output path.
- Reset values: `pc_eo`=0, `inst_eo`=0x00000013, all others 0 or the bubble encodings above.
- Reset asserted mid-stall or mid-freeze: reset wins at that edge. The next edge after release performs a normal prioritised action.
- `flush_i` and `pc_stopFlag_i` together: one bubble, counted as flush only.
- Back-to-back `pc_stopFlag_i`: one bubble per cycle. No limit is enforced.

## Configuration
- `ID_EX_PERF_CNT_EN` defined: `bubble_cnt_o` and `flush_cnt_o` are live counters as described.
- Not defined: no counter flops; both outputs are tied to 32'h0.
- Pipeline behaviour is identical in both builds.

## Test plan
- Reset: hold `rst`=1 with `inst_di`=0x00500093 -> `inst_eo`=0x00000013, `valid_eo`=0, `RegWEn_eo`=0. Next cycle with `rst`=0 -> `inst_eo`=0x00500093, `valid_eo`=1.
- Load-use: `pc_stopFlag_i`=1 for one cycle with `RegWEn_di`=1, `AddrD_di`=5 -> `RegWEn_eo`=0, `AddrD_eo`=0, `valid_eo`=0, `bubble_cnt_o`=1. Next cycle loads the instruction.
- Flush vs stall: `flush_i`=1 and `pc_stopFlag_i`=1 together -> bubble, `flush_cnt_o`=1, `bubble_cnt_o` unchanged.
- Freeze: `mem_wait_i`=1 for 3 cycles while `flush_i`=1 and `inst_di` changes -> all outputs and counters hold their pre-freeze values.
- Forwarding selects: `ASel_di`=`ASEL_ALU`, `BSel_di`=`BSEL_DATAD` -> same values on `ASel_eo`/`BSel_eo` one cycle later. Under a bubble -> `ASEL_REG`/`BSEL_REG`.
- Counter wrap, `ID_EX_PERF_CNT_EN` defined: force `bubble_cnt` to 0xFFFFFFFF, apply one stall -> 0. Without the macro, both counters read 0 after 10 stalls.
